// File: rtl/execute_stage_if.sv
// EX-stage signal bundle: ID/EX inputs, writeback feedback, branch redirect and EX/MEM outputs.
// The "slave" modport is the execute stage itself; "master" is the surrounding pipeline.
interface execute_stage_if #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  RegWrite_E;
  logic                  ALUSrc_E;
  logic                  MemWrite_E;
  logic                  MemRead_E;
  logic                  Branch_E;
  logic                  MemtoReg_E;
  logic [3:0]            control_o_E;
  logic [DAT_WIDTH-1:0]  ImmExt_E;
  logic [DAT_WIDTH-1:0]  rdata1_E;
  logic [DAT_WIDTH-1:0]  rdata2_E;
  logic [4:0]            rs1_E;
  logic [4:0]            rs2_E;
  logic [4:0]            rd_E;
  logic [ADDR_WIDTH-1:0] PC_E;
  logic [ADDR_WIDTH-1:0] PC_4E;
  logic                  RegWrite_W;
  logic [4:0]            rd_W;
  logic [DAT_WIDTH-1:0]  Result_W;
  logic                  PCSrc_E;
  logic [ADDR_WIDTH-1:0] PCTarget_E;
  logic                  stall_E;
  logic                  RegWrite_M;
  logic                  MemWrite_M;
  logic                  MemRead_M;
  logic                  MemtoReg_M;
  logic [DAT_WIDTH-1:0]  ALUResult_M;
  logic [DAT_WIDTH-1:0]  WriteData_M;
  logic [4:0]            rd_M;
  logic [ADDR_WIDTH-1:0] PC_4M;

  modport master (
    output RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, MemtoReg_E,
    output control_o_E, ImmExt_E, rdata1_E, rdata2_E, rs1_E, rs2_E, rd_E, PC_E, PC_4E,
    output RegWrite_W, rd_W, Result_W,
    input  PCSrc_E, PCTarget_E, stall_E,
    input  RegWrite_M, MemWrite_M, MemRead_M, MemtoReg_M, ALUResult_M, WriteData_M, rd_M, PC_4M
  );

  modport slave (
    input  RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, MemtoReg_E,
    input  control_o_E, ImmExt_E, rdata1_E, rdata2_E, rs1_E, rs2_E, rd_E, PC_E, PC_4E,
    input  RegWrite_W, rd_W, Result_W,
    output PCSrc_E, PCTarget_E, stall_E,
    output RegWrite_M, MemWrite_M, MemRead_M, MemtoReg_M, ALUResult_M, WriteData_M, rd_M, PC_4M
  );
endinterface

// File: rtl/execute_stage.sv
// Pipeline EX stage: forwarding, ALU, BEQ resolution and the EX/MEM register.
// Define EXEC_MUL_EN to add an iterative 32-step shift-add MUL (code 1010) that stalls upstream.
module execute_stage #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  execute_stage_if.slave ex
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
`ifdef EXEC_MUL_EN
  localparam logic [3:0] ALU_MUL = 4'b1010;
`endif

  logic [DAT_WIDTH-1:0] src_a;
  logic [DAT_WIDTH-1:0] fwd_b;
  logic [DAT_WIDTH-1:0] src_b;
  logic [DAT_WIDTH-1:0] alu_result;
  logic                 zero;
  logic                 stall;

  logic                  reg_write_m_q, reg_write_m_d;
  logic                  mem_write_m_q, mem_write_m_d;
  logic                  mem_read_m_q,  mem_read_m_d;
  logic                  mem_to_reg_m_q, mem_to_reg_m_d;
  logic [DAT_WIDTH-1:0]  alu_result_m_q, alu_result_m_d;
  logic [DAT_WIDTH-1:0]  write_data_m_q, write_data_m_d;
  logic [4:0]            rd_m_q, rd_m_d;
  logic [ADDR_WIDTH-1:0] pc_4m_q, pc_4m_d;

  // MEM has priority over WB because it holds the younger write to the same register.
  always_comb begin
    src_a = ex.rdata1_E;
    if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == ex.rs1_E))
      src_a = alu_result_m_q;
    else if (ex.RegWrite_W && (ex.rd_W != 5'd0) && (ex.rd_W == ex.rs1_E))
      src_a = ex.Result_W;

    fwd_b = ex.rdata2_E;
    if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == ex.rs2_E))
      fwd_b = alu_result_m_q;
    else if (ex.RegWrite_W && (ex.rd_W != 5'd0) && (ex.rd_W == ex.rs2_E))
      fwd_b = ex.Result_W;

    src_b = ex.ALUSrc_E ? ex.ImmExt_E : fwd_b;
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_e;

  mul_state_e           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0] mcand_q, mcand_d;
  logic [DAT_WIDTH-1:0] mplier_q, mplier_d;
  logic [DAT_WIDTH-1:0] acc_q, acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Operands are captured once in IDLE so later forwarding cannot disturb the product.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex.control_o_E == ALU_MUL) begin
          mcand_d  = src_a;
          mplier_d = src_b;
          acc_d    = '0;
          cnt_d    = '0;
          stall    = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (mplier_q[0])
          acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_result = '0;
    case (ex.control_o_E)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = {{(DAT_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_SRL: alu_result = src_a >> src_b[4:0];
`ifdef EXEC_MUL_EN
      ALU_MUL: alu_result = (state_q == S_DONE) ? acc_q : '0;
`endif
      default: alu_result = '0;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign ex.PCSrc_E    = ex.Branch_E & zero;
  assign ex.PCTarget_E = ex.PC_E + ADDR_WIDTH'(ex.ImmExt_E);
  assign ex.stall_E    = stall;

  // A stalled cycle inserts a bubble so MEM never sees a partial multiply.
  always_comb begin
    reg_write_m_d  = 1'b0;
    mem_write_m_d  = 1'b0;
    mem_read_m_d   = 1'b0;
    mem_to_reg_m_d = 1'b0;
    alu_result_m_d = '0;
    write_data_m_d = '0;
    rd_m_d         = '0;
    pc_4m_d        = '0;
    if (!stall) begin
      reg_write_m_d  = ex.RegWrite_E;
      mem_write_m_d  = ex.MemWrite_E;
      mem_read_m_d   = ex.MemRead_E;
      mem_to_reg_m_d = ex.MemtoReg_E;
      alu_result_m_d = alu_result;
      write_data_m_d = fwd_b;
      rd_m_d         = ex.rd_E;
      pc_4m_d        = ex.PC_4E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_read_m_q   <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      rd_m_q         <= '0;
      pc_4m_q        <= '0;
    end else begin
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      mem_read_m_q   <= mem_read_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      rd_m_q         <= rd_m_d;
      pc_4m_q        <= pc_4m_d;
    end
  end

  assign ex.RegWrite_M  = reg_write_m_q;
  assign ex.MemWrite_M  = mem_write_m_q;
  assign ex.MemRead_M   = mem_read_m_q;
  assign ex.MemtoReg_M  = mem_to_reg_m_q;
  assign ex.ALUResult_M = alu_result_m_q;
  assign ex.WriteData_M = write_data_m_q;
  assign ex.rd_M        = rd_m_q;
  assign ex.PC_4M       = pc_4m_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage. Consumes the ID/EX register outputs of the decode stage: control bits, ALU control code, operands, immediate, register indices and PCs.
- Performs operand forwarding, ALU operation and branch resolution (BEQ).
- Drives the EX/MEM pipeline register towards the memory stage, and returns the branch redirect (PCSrc_E, PCTarget_E) to fetch.

Parameters:
- DAT_WIDTH, 32, datapath width; only 32 is supported.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, MemtoReg_E  in  1 each  control bits from ID/EX.
- control_o_E  in  4  ALU operation code.
- ImmExt_E, rdata1_E, rdata2_E  in  32  immediate and register operands.
- rs1_E, rs2_E, rd_E  in  5  register indices.
- PC_E, PC_4E  in  32  instruction PC and PC+4.
- RegWrite_M  in  1  RegWrite of the instruction in MEM (fed back from own output).
- RegWrite_W  in  1  RegWrite of the instruction in WB.
- rd_W  in  5  destination register of the instruction in WB.
- Result_W  in  32  writeback value.
- PCSrc_E  out  1  branch taken (combinational).
- PCTarget_E  out  32  branch target (combinational).
- stall_E  out  1  EX busy; upstream holds ID/EX (constant 0 without the optional feature).
- RegWrite_M, MemWrite_M, MemRead_M, MemtoReg_M  out  1  registered control bits.
- ALUResult_M  out  32  registered ALU result.
- WriteData_M  out  32  registered forwarded rs2 value (store data).
- rd_M  out  5  registered destination register.
- PC_4M  out  32  registered PC+4.

Behaviour:
- Reset: all registered outputs are 0; the MUL FSM is in IDLE. PCSrc_E and PCTarget_E follow their combinational inputs.
- Forwarding for operand A, evaluated in priority order:
  - If RegWrite_M && rd_M!=0 && rd_M==rs1_E, use ALUResult_M.
  - Else if RegWrite_W && rd_W!=0 && rd_W==rs1_E, use Result_W.
  - Else use rdata1_E.
- Forwarding for operand B: identical logic using rs2_E and rdata2_E. Call the result fwdB.
- SrcA = forwarded A. SrcB = ALUSrc_E ? ImmExt_E : fwdB.
- ALU codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (wraps mod 2^32).
  - 0111 SLT, signed, result 1/0.
  - 0011 XOR; 0100 SLL by SrcB[4:0]; 0101 SRL by SrcB[4:0].
  - 1010 MUL, optional feature only.
  - Any other code: result 0.
- Zero = (ALU result == 0).
- Branch: PCSrc_E = Branch_E & Zero. PCTarget_E = PC_E + ImmExt_E, wrapping mod 2^32.
- EX/MEM register is updated every rising edge and captures:
  - the four control bits, the ALU result, fwdB, rd_E and PC_4E;
  - ALUSrc_E and Branch_E are not propagated.
- Single-cycle ops: latency 1 cycle from ID/EX to EX/MEM.
- Bubble, whenever stall_E=1: EX/MEM loads RegWrite_M=MemWrite_M=MemRead_M=MemtoReg_M=0, rd_M=0, data fields 0.
- Reset asserted mid-operation clears all state immediately; no partial result is ever committed.

Optional Feature:
- Macro EXEC_MUL_EN. When defined, code 1010 is MUL: an iterative shift-add multiply returning the low 32 bits.
- FSM states and transitions:
  - IDLE: if code==1010, latch SrcA and SrcB, clear the 5-bit counter, go to BUSY; stall_E=1 in this cycle.
  - BUSY: one shift-add step per cycle; go to DONE after 32 steps (counter wraps 31 -> 0); stall_E=1.
  - DONE: stall_E=0; the ALU result is the product; EX/MEM captures it; go to IDLE.
- Total EX occupancy is 34 cycles.
- Operands are latched at IDLE, so forwarding changes during BUSY have no effect.
- Back-to-back MULs each take 34 cycles.
- Not defined: no FSM; stall_E ties to 0; code 1010 yields 0.

Test Plan:
- Reset asserted for 3 cycles with nonzero inputs -> all *_M outputs read 0; stall_E=0.
- ADD, rdata1_E=5, rdata2_E=7, ALUSrc_E=0, RegWrite_E=1, rd_E=3 -> next cycle ALUResult_M=12, rd_M=3, RegWrite_M=1.
- Back-to-back dependency: first SUB with rs1 value 10 and rs2 value 3 writes x3. Next instruction is ADD with rs1_E=3, rdata1_E=0, and ImmExt_E=1, ALUSrc_E=1 -> ALUResult_M=8, forwarded from M. Same check with M idle and WB writing x3=20 -> ALUResult_M=21. Same check with rs1_E=0 -> no forwarding.
- BEQ with PC_E=0x100, ImmExt_E=0xFFFFFFF0, equal operands 9 and 9 -> PCSrc_E=1, PCTarget_E=0xF0. With operands 9 and 8 -> PCSrc_E=0.
- SLT with operands 0xFFFFFFFF and 1 -> ALUResult_M=1. SRL of 0x80000000 by SrcB=0x21 -> 0x40000000 (shift amount 1).
- EXEC_MUL_EN defined, MUL 0x00010001 x 0x00010001 -> stall_E high for 33 cycles with bubbles in EX/MEM, then ALUResult_M=0x00020001. Reset asserted at cycle 10 of the multiply -> stall_E=0, FSM in IDLE, *_M outputs read 0.
